// File: rtl/ascon128_aead.sv
// ascon128_aead: single-lane ASCON-128 AEAD core, one AD block then PT_BLOCKS plaintext blocks
module ascon128_aead #(
  parameter int          PT_BLOCKS = 4,
  parameter logic [63:0] IV        = 64'h80400c0600000000
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic         data_valid_i,
  input  logic [63:0]  data_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  output logic         cipher_valid_o,
  output logic [63:0]  cipher_o,
  output logic         end_o,
  output logic [127:0] tag_o
);
  localparam int BW = (PT_BLOCKS > 1) ? $clog2(PT_BLOCKS) : 1;
  typedef enum logic [2:0] {IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE} state_t;
  state_t         r_state, w_state;
  logic [319:0]   r_s, w_s, w_rnd;
  logic [3:0]     r_i, w_i;
  logic [BW-1:0]  r_blk, w_blk;
  logic [63:0]    r_cipher, w_cipher, w_x0d;
  logic [127:0]   r_tag, w_tag;
  logic           r_cv, w_cv, r_end, w_end, r_st, r_dv;
  logic           w_st_ev, w_dv_ev, w_last_rnd, w_last_blk;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // one ASCON round: constant addition, bit-sliced S-box, linear diffusion
  function automatic logic [319:0] f_round(input logic [319:0] s, input logic [3:0] i);
    logic [63:0] a0, a1, a2, a3, a4, c0, c1, c2, c3, c4;
    a1 = s[255:192];
    a3 = s[127:64];
    a0 = s[319:256] ^ s[63:0];
    a4 = s[63:0] ^ s[127:64];
    a2 = s[191:128] ^ {56'b0, ~i, i} ^ s[255:192];
    c0 = a0 ^ (~a1 & a2);
    c1 = a1 ^ (~a2 & a3);
    c2 = a2 ^ (~a3 & a4);
    c3 = a3 ^ (~a4 & a0);
    c4 = a4 ^ (~a0 & a1);
    c1 = c1 ^ c0;
    c0 = c0 ^ c4;
    c3 = c3 ^ c2;
    c2 = ~c2;
    return {c0 ^ ror(c0, 19) ^ ror(c0, 28), c1 ^ ror(c1, 61) ^ ror(c1, 39),
            c2 ^ ror(c2, 1) ^ ror(c2, 6), c3 ^ ror(c3, 10) ^ ror(c3, 17),
            c4 ^ ror(c4, 7) ^ ror(c4, 41)};
  endfunction

  assign w_rnd          = f_round(r_s, r_i);
  assign w_st_ev        = start_i & ~r_st;
  assign w_dv_ev        = data_valid_i & ~r_dv;
  assign w_last_rnd     = r_i == 4'd11;
  assign w_last_blk     = r_blk == BW'(PT_BLOCKS - 1);
  assign w_x0d          = r_s[319:256] ^ data_i;
  assign cipher_valid_o = r_cv;
  assign cipher_o       = r_cipher;
  assign end_o          = r_end;
  assign tag_o          = r_tag;

  // next-state and datapath decisions for each phase of the message
  always_comb begin
    w_state  = r_state;
    w_s      = r_s;
    w_i      = r_i + 4'd1;
    w_blk    = r_blk;
    w_cipher = r_cipher;
    w_cv     = 1'b0;
    w_tag    = r_tag;
    w_end    = r_end;
    case (r_state)
      IDLE, DONE: if (w_st_ev) begin
        w_s     = {IV, key_i, nonce_i};
        w_end   = 1'b0;
        w_i     = 4'd0;
        w_blk   = '0;
        w_state = INIT;
      end
      INIT: begin
        w_s     = w_rnd ^ {192'b0, w_last_rnd ? key_i : 128'b0};
        w_state = w_last_rnd ? WAIT_AD : INIT;
      end
      WAIT_AD: if (w_dv_ev) begin
        w_s[319:256] = w_x0d;
        w_i          = 4'd6;
        w_state      = AD;
      end
      AD: begin
        w_s     = w_rnd ^ {319'b0, w_last_rnd};
        w_state = w_last_rnd ? WAIT_PT : AD;
      end
      WAIT_PT: if (w_dv_ev) begin
        w_s[319:256] = w_x0d;
        w_s[255:128] = w_last_blk ? r_s[255:128] ^ key_i : r_s[255:128];
        w_cipher     = w_x0d;
        w_cv         = 1'b1;
        w_blk        = w_last_blk ? '0 : r_blk + 1'b1;
        w_i          = w_last_blk ? 4'd0 : 4'd6;
        w_state      = w_last_blk ? FINAL : PT;
      end
      PT: begin
        w_s     = w_rnd;
        w_state = w_last_rnd ? WAIT_PT : PT;
      end
      FINAL: begin
        w_s = w_rnd;
        if (w_last_rnd) begin
          w_tag   = w_rnd[127:0] ^ key_i;
          w_end   = 1'b1;
          w_state = DONE;
        end
      end
    endcase
  end

  // state register, datapath registers and input edge detectors
  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      r_state  <= IDLE;
      r_s      <= '0;
      r_i      <= '0;
      r_blk    <= '0;
      r_cipher <= '0;
      r_tag    <= '0;
      r_cv     <= 1'b0;
      r_end    <= 1'b0;
      r_st     <= 1'b0;
      r_dv     <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_s      <= w_s;
      r_i      <= w_i;
      r_blk    <= w_blk;
      r_cipher <= w_cipher;
      r_tag    <= w_tag;
      r_cv     <= w_cv;
      r_end    <= w_end;
      r_st     <= start_i;
      r_dv     <= data_valid_i;
    end
  end
endmodule

// File: tb/tb_ascon128_aead.sv
// tb_ascon128_aead: self-checking bench for ascon128_aead against an array-based ASCON-128 model
module tb_ascon128_aead;
  localparam logic [63:0]  IV = 64'h80400c0600000000;
  localparam logic [127:0] K  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] N  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [63:0]  A  = 64'h3230323380000000;
  localparam logic [255:0] P  = {64'h436F6E636576657A, 64'h204153434F4E2065,
                                 64'h6E2053797374656D, 64'h566572696C6F6780};
  localparam logic [4:0] SB [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                     5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                     5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                     5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int RA [5] = '{19, 61, 1, 10, 7};
  localparam int RB [5] = '{28, 39, 6, 17, 41};

  logic         clock_i = 1'b0, resetb_i = 1'b1, start_i = 1'b0, data_valid_i = 1'b0;
  logic [63:0]  data_i = '0;
  logic [127:0] key_i = '0, nonce_i = '0;
  logic         cipher_valid_o, end_o;
  logic [63:0]  cipher_o;
  logic [127:0] tag_o;

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [63:0] cq[$];
  int pc[$];
  int end_cyc = -1;
  bit end_prev = 1'b0;
  int cbase;
  int ev[5];
  logic end_after_start;
  logic [255:0] ec;
  logic [127:0] et;

  ascon128_aead dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .data_valid_i(data_valid_i),
    .data_i(data_i), .key_i(key_i), .nonce_i(nonce_i), .cipher_valid_o(cipher_valid_o),
    .cipher_o(cipher_o), .end_o(end_o), .tag_o(tag_o)
  );

  always #5 clock_i = ~clock_i;
  always @(posedge clock_i) cyc <= cyc + 1;

  always @(negedge clock_i) begin
    if (cipher_valid_o === 1'b1) begin
      cq.push_back(cipher_o);
      pc.push_back(cyc);
    end
    if (end_o === 1'b1 && !end_prev) end_cyc = cyc;
    end_prev = end_o === 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [63:0] rr(input logic [63:0] w, input int n);
    return (w >> n) | (w << (64 - n));
  endfunction

  function automatic logic [319:0] perm(input logic [319:0] s, input int nr);
    logic [63:0] x[5];
    logic [4:0] v;
    for (int k = 0; k < 5; k++) x[k] = s[319-64*k -: 64];
    for (int r = 12 - nr; r < 12; r++) begin
      x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        v = SB[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
        {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]} = v;
      end
      for (int k = 0; k < 5; k++) x[k] = x[k] ^ rr(x[k], RA[k]) ^ rr(x[k], RB[k]);
    end
    for (int k = 0; k < 5; k++) s[319-64*k -: 64] = x[k];
    return s;
  endfunction

  task automatic model(input logic [127:0] k, input logic [127:0] n, input logic [63:0] ad,
                       input logic [255:0] pt, output logic [255:0] c, output logic [127:0] t);
    logic [319:0] s;
    s = perm({IV, k, n}, 12);
    s[127:0] = s[127:0] ^ k;
    s[319:256] = s[319:256] ^ ad;
    s = perm(s, 6);
    s[0] = ~s[0];
    for (int j = 0; j < 4; j++) begin
      s[319:256] = s[319:256] ^ pt[255-64*j -: 64];
      c[255-64*j -: 64] = s[319:256];
      if (j < 3) s = perm(s, 6);
    end
    s[255:128] = s[255:128] ^ k;
    s = perm(s, 12);
    t = s[127:0] ^ k;
  endtask

  task automatic run_msg(input logic [127:0] k, input logic [127:0] n, input logic [63:0] ad,
                         input logic [255:0] pt, input bit hold_st, input bit inject, input bit abort);
    cbase = cq.size();
    key_i = k;
    nonce_i = n;
    data_valid_i = 1'b0;
    start_i = 1'b0;
    @(posedge clock_i); #1;
    start_i = 1'b1;
    @(posedge clock_i); #1;
    end_after_start = end_o;
    if (!hold_st) start_i = 1'b0;
    if (inject) begin
      data_i = {$urandom, $urandom};
      data_valid_i = 1'b1;
      @(posedge clock_i); #1;
      data_valid_i = 1'b0;
    end
    repeat (14) begin @(posedge clock_i); #1; end
    for (int b = 0; b < 5; b++) begin
      data_i = (b == 0) ? ad : pt[255-64*(b-1) -: 64];
      data_valid_i = 1'b1;
      ev[b] = cyc;
      for (int h = 0; h < 5; h++) begin
        @(posedge clock_i); #1;
        if (inject && b == 2 && !hold_st) start_i = (h == 0);
      end
      data_valid_i = 1'b0;
      repeat (3) begin @(posedge clock_i); #1; end
    end
    if (abort) begin
      resetb_i = 1'b1;
      @(posedge clock_i); #1;
      resetb_i = 1'b0;
    end else begin
      for (int t = 0; t < 40 && end_cyc <= ev[4]; t++) begin @(posedge clock_i); #1; end
    end
  endtask

  task automatic test_reset;
    resetb_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock_i); #1;
      start_i = 1'($urandom); data_valid_i = 1'($urandom); data_i = {$urandom, $urandom};
      key_i = {$urandom, $urandom, $urandom, $urandom}; nonce_i = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clock_i);
      checks++;
      if ({cipher_valid_o, cipher_o, end_o, tag_o} !== 194'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got cv=%b c=%h end=%b tag=%h, want all 0", i, cipher_valid_o, cipher_o, end_o, tag_o);
      end
    end
    @(posedge clock_i); #1;
    resetb_i = 1'b0;
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_valid_i = 1'($urandom); data_i = {$urandom, $urandom};
      @(negedge clock_i);
      checks++;
      if ({cipher_valid_o, cipher_o, end_o, tag_o} !== 194'b0) begin
        errors++;
        $display("FAIL idle_quiet cycle %0d: got cv=%b c=%h end=%b tag=%h, want all 0", i, cipher_valid_o, cipher_o, end_o, tag_o);
      end
      @(posedge clock_i); #1;
    end
    data_valid_i = 1'b0;
  endtask

  task automatic test_full_message;
    logic [63:0] got;
    model(K, N, A, P, ec, et);
    run_msg(K, N, A, P, 0, 0, 0);
    checks++;
    if (cq.size() - cbase !== 4) begin
      errors++;
      $display("FAIL full_pulses: got %0d cipher pulses, want 4", cq.size() - cbase);
    end
    for (int j = 0; j < 4; j++) begin
      got = (cbase + j < cq.size()) ? cq[cbase+j] : 'x;
      checks++;
      if (got !== ec[255-64*j -: 64]) begin
        errors++;
        $display("FAIL full_cipher[%0d]: got %h, want %h", j, got, ec[255-64*j -: 64]);
      end
      checks++;
      if (((cbase + j < pc.size()) ? pc[cbase+j] - ev[j+1] : -1) !== 1) begin
        errors++;
        $display("FAIL full_cipher_latency[%0d]: got %0d, want 1", j, (cbase + j < pc.size()) ? pc[cbase+j] - ev[j+1] : -1);
      end
    end
    checks++;
    if (end_cyc - ev[4] !== 13) begin
      errors++;
      $display("FAIL full_end_latency: got %0d, want 13", end_cyc - ev[4]);
    end
    checks++;
    if (tag_o !== et || end_o !== 1'b1) begin
      errors++;
      $display("FAIL full_tag: got tag=%h end=%b, want tag=%h end=1", tag_o, end_o, et);
    end
  endtask

  task automatic test_level_inputs;
    logic [63:0] got;
    model(K, N, A, P, ec, et);
    run_msg(K, N, A, P, 1, 0, 0);
    for (int j = 0; j < 4; j++) begin
      got = (cbase + j < cq.size()) ? cq[cbase+j] : 'x;
      checks++;
      if (got !== ec[255-64*j -: 64]) begin
        errors++;
        $display("FAIL level_cipher[%0d]: got %h, want %h", j, got, ec[255-64*j -: 64]);
      end
    end
    repeat (20) begin @(posedge clock_i); #1; end
    checks++;
    if (cq.size() - cbase !== 4 || end_o !== 1'b1 || tag_o !== et) begin
      errors++;
      $display("FAIL level_hold: got pulses=%0d end=%b tag=%h, want pulses=4 end=1 tag=%h", cq.size() - cbase, end_o, tag_o, et);
    end
    start_i = 1'b0;
  endtask

  task automatic test_ignored_events;
    logic [63:0] got;
    model(K, N, A, P, ec, et);
    run_msg(K, N, A, P, 0, 1, 0);
    checks++;
    if (cq.size() - cbase !== 4) begin
      errors++;
      $display("FAIL ignored_pulses: got %0d cipher pulses, want 4", cq.size() - cbase);
    end
    for (int j = 0; j < 4; j++) begin
      got = (cbase + j < cq.size()) ? cq[cbase+j] : 'x;
      checks++;
      if (got !== ec[255-64*j -: 64]) begin
        errors++;
        $display("FAIL ignored_cipher[%0d]: got %h, want %h", j, got, ec[255-64*j -: 64]);
      end
    end
    checks++;
    if (tag_o !== et || end_o !== 1'b1) begin
      errors++;
      $display("FAIL ignored_tag: got tag=%h end=%b, want tag=%h end=1", tag_o, end_o, et);
    end
  endtask

  task automatic test_reset_final;
    model(K, N, A, P, ec, et);
    run_msg(K, N, A, P, 0, 0, 1);
    @(negedge clock_i);
    checks++;
    if ({cipher_valid_o, cipher_o, end_o, tag_o} !== 194'b0) begin
      errors++;
      $display("FAIL reset_final_clear: got cv=%b c=%h end=%b tag=%h, want all 0", cipher_valid_o, cipher_o, end_o, tag_o);
    end
    run_msg(K, N, A, P, 0, 0, 0);
    checks++;
    if (tag_o !== et || end_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_final_retag: got tag=%h end=%b, want tag=%h end=1", tag_o, end_o, et);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] got;
    model(K, N, A, P, ec, et);
    for (int m = 0; m < 2; m++) begin
      run_msg(K, N, A, P, 0, 0, 0);
      checks++;
      if (end_after_start !== 1'b0) begin
        errors++;
        $display("FAIL b2b_end_drop[%0d]: got end=%b after start, want 0", m, end_after_start);
      end
      got = (cbase + 3 < cq.size()) ? cq[cbase+3] : 'x;
      checks++;
      if (tag_o !== et || got !== ec[63:0]) begin
        errors++;
        $display("FAIL b2b_result[%0d]: got tag=%h c3=%h, want tag=%h c3=%h", m, tag_o, got, et, ec[63:0]);
      end
    end
  endtask

  task automatic test_random;
    logic [127:0] k, n;
    logic [63:0] ad, got;
    logic [255:0] pt;
    for (int m = 0; m < 3; m++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      n = {$urandom, $urandom, $urandom, $urandom};
      ad = {$urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      model(k, n, ad, pt, ec, et);
      run_msg(k, n, ad, pt, 0, 0, 0);
      for (int j = 0; j < 4; j++) begin
        got = (cbase + j < cq.size()) ? cq[cbase+j] : 'x;
        checks++;
        if (got !== ec[255-64*j -: 64]) begin
          errors++;
          $display("FAIL random_cipher[%0d][%0d]: got %h, want %h", m, j, got, ec[255-64*j -: 64]);
        end
      end
      checks++;
      if (tag_o !== et) begin
        errors++;
        $display("FAIL random_tag[%0d]: got %h, want %h", m, tag_o, et);
      end
    end
  endtask

  initial begin
    test_reset;
    test_full_message;
    test_level_inputs;
    test_ignored_events;
    test_reset_final;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ascon128_aead.md
Name: ascon128_aead

Overview:
- Single-lane ASCON-128 authenticated-encryption core: 128-bit key, 128-bit nonce, 64-bit rate, pa=12 and pb=6 rounds.
- Processes exactly one 64-bit associated-data block, then PT_BLOCKS plaintext blocks.
- Emits one 64-bit ciphertext word per plaintext block, then the 128-bit tag.
- Top-level crypto block, fed by a host/controller that supplies pre-padded 64-bit words.

Parameters:
- PT_BLOCKS, 4, number of 64-bit plaintext blocks per message (last block already padded by host).
- IV, 64'h80400c0600000000, ASCON-128 initialisation vector.

Ports:
- clock_i  in  1  single clock; all state updates on rising edge.
- resetb_i  in  1  synchronous, active-high reset (despite the name).
- start_i  in  1  level; a 0->1 transition starts a message.
- data_valid_i  in  1  level; a 0->1 transition presents one data_i block.
- data_i  in  64  AD or plaintext block; bit 63 = first message byte.
- key_i  in  128  key K; held stable for the whole message.
- nonce_i  in  128  nonce N; held stable for the whole message.
- cipher_valid_o  out  1  one-cycle pulse, cipher_o valid.
- cipher_o  out  64  ciphertext block; holds its last value.
- end_o  out  1  high when tag_o is valid.
- tag_o  out  128  authentication tag.

Behaviour:
- Reset (resetb_i=1 at a clock edge): FSM to IDLE; 320-bit state, cipher_o, tag_o := 0; cipher_valid_o, end_o := 0; edge-detect registers := 0. Applies from any state, mid-operation included.
- Edge detection: registered copies of start_i and data_valid_i. Event = current 1 AND previous 0. Level-held inputs fire once.
- State S = x0||x1||x2||x3||x4, x0 is the most significant word.
- Permutation: one round per cycle, applied in this order:
  - constant addition x2 ^= {56'b0, ((0xF-i)<<4)|i};
  - 5-bit ASCON S-box, bit-sliced across x0..x4;
  - linear layer x0^=ror19^ror28, x1^=ror61^ror39, x2^=ror1^ror6, x3^=ror10^ror17, x4^=ror7^ror41.
  - pa uses i=0..11; pb uses i=6..11.
- FSM states: IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE.
- IDLE/DONE + start event: S := IV||K||N, end_o := 0, go to INIT. Start events in any other state are ignored.
- INIT: 12 rounds. After the last round, x3||x4 ^= K, then WAIT_AD.
- WAIT_AD + data event: x0 ^= data_i, go to AD.
- AD: 6 rounds. After the last round, x4 ^= 1 (domain separation), then WAIT_PT.
- WAIT_PT + data event for blocks 1..PT_BLOCKS-1:
  - x0 ^= data_i; cipher_o := x0 ^ data_i; cipher_valid_o = 1 on the next cycle for exactly one cycle;
  - go to PT: 6 rounds, then back to WAIT_PT.
- WAIT_PT + data event for the last block:
  - x0 ^= data_i; cipher_o as above;
  - x1||x2 ^= K; go to FINAL.
- FINAL: 12 rounds. Then tag_o := (x3||x4) ^ K, end_o := 1, go to DONE.
- DONE: end_o and tag_o hold until reset or a new start event.
- Data events while busy (INIT/AD/PT/FINAL), in IDLE or in DONE are ignored. The host waits at least 7 cycles between blocks.
- Block counter counts 0..PT_BLOCKS-1 and clears on a start event.
- Latency from data event:
  - cipher_valid_o 1 cycle after the event;
  - next block accepted ≥7 cycles after the event;
  - end_o 13 cycles after the last-block event.
- Start-to-ready: WAIT_AD is reached 13 cycles after the start event.

Test Plan:
- Reset: hold resetb_i=1 for 5 cycles with random inputs -> all outputs 0. Deassert, start_i stays low -> outputs stay 0.
- Full message:
  - inputs: K=000102030405060708090A0B0C0D0E0F, N=00112233445566778899aabbccddeeff, AD=3230323380000000;
  - PT = 436F6E636576657A, 204153434F4E2065, 6E2053797374656D, 566572696C6F6780 (data_valid_i held 5 cycles each);
  - expect exactly 4 cipher_valid_o pulses;
  - cipher_o and tag_o equal the golden ASCON-128 model (same padded blocks);
  - end_o rises 13 cycles after the last event.
- Level-held inputs: start_i held high forever and data_valid_i held 5 cycles -> single start, single block consumed each time.
- Ignored events: start pulse during PT, and data pulse during INIT -> no state change; results identical to the full-message case.
- Reset mid-FINAL: outputs clear next cycle. A new start then reproduces the same tag.
- Back-to-back messages: start event in DONE -> end_o drops, second identical message yields an identical tag.
